envelope_vca: RTL

- Voltage-controlled-amplifier stage directly downstream of the ADSR envelope generator.
- Multiplies the oscillator/filter sample stream by the envelope output level Env_lvl, using an optional slewed gain tracker to suppress zipper noise.
- Applies a selectable post-gain shift with saturation and a sticky clip flag.
- Output feeds the mixer/DAC interface with a valid/ready handshake.

---
 rtl/vca_pkg.sv | 11 +
 rtl/envelope_vca_if.sv | 8 +
 rtl/vca_gain_slew.sv | 33 +++
 rtl/envelope_vca.sv | 70 +++++++
 4 files changed

// File: rtl/vca_pkg.sv
// vca_pkg: shared widths, rounding/saturation constants and gain-shift codes for envelope_vca
package vca_pkg;
  localparam int SAMPLE_W = 16;
  localparam int LEVEL_W = 16;
  localparam int PROD_W = SAMPLE_W + LEVEL_W + 1;
  localparam int SCALE_W = 20;
  localparam int RND = 1 << 15;
  localparam int SMP_MAX = 32767;
  localparam int SMP_MIN = -32768;
  typedef enum logic [1:0] {SH_X1, SH_X2, SH_X4, SH_X8} gain_sh_e;
endpackage

// File: rtl/envelope_vca_if.sv
// envelope_vca_if: valid/ready sample stream; the producer uses master, the consumer uses slave
interface envelope_vca_if #(parameter int W = 16);
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/vca_gain_slew.sv
// vca_gain_slew: applied-gain tracker; slews by SLEW_STEP per tick with VCA_SLEW_EN, else follows Env_lvl directly
module vca_gain_slew
  import vca_pkg::*;
#(
  parameter int SLEW_STEP = 64
) (
  input  logic               Sys_clk,
  input  logic               Vca_rst_n,
  input  logic               Vca_ce,
  input  logic               Syn_tick,
  input  logic [LEVEL_W-1:0] Env_lvl,
  output logic [LEVEL_W-1:0] g_cur
);
  logic [LEVEL_W-1:0] g_cur_q, g_cur_d;
`ifdef VCA_SLEW_EN
  localparam logic [LEVEL_W:0] STEP = (LEVEL_W+1)'(SLEW_STEP);
  logic [LEVEL_W:0] up, dn;
  // step toward Env_lvl by at most STEP, landing exactly on it when close so it never overshoots or wraps
  always_comb begin
    up = {1'b0, Env_lvl} - {1'b0, g_cur_q};
    dn = {1'b0, g_cur_q} - {1'b0, Env_lvl};
    g_cur_d = !(Syn_tick & Vca_ce) ? g_cur_q :
              (Env_lvl >= g_cur_q) ? ((up <= STEP) ? Env_lvl : g_cur_q + STEP[LEVEL_W-1:0]) :
              ((dn <= STEP) ? Env_lvl : g_cur_q - STEP[LEVEL_W-1:0]);
  end
`else
  // no slew: take the envelope level on every enabled tick
  always_comb g_cur_d = (Syn_tick & Vca_ce) ? Env_lvl : g_cur_q;
`endif
  // applied-gain register, zero after reset
  always_ff @(posedge Sys_clk) g_cur_q <= !Vca_rst_n ? '0 : g_cur_d;
  assign g_cur = g_cur_q;
endmodule

// File: rtl/envelope_vca.sv
// envelope_vca: two-stage VCA (gain multiply, round/shift/saturate) with sticky clip; optional slew via VCA_SLEW_EN
module envelope_vca
  import vca_pkg::*;
#(
  parameter int SLEW_STEP = 64
) (
  input  logic               Sys_clk,
  input  logic               Vca_rst_n,
  input  logic               Vca_ce,
  input  logic               Syn_tick,
  input  logic [LEVEL_W-1:0] Env_lvl,
  input  logic [1:0]         Gain_sh,
  envelope_vca_if.slave      smp_if,
  envelope_vca_if.master     out_if,
  output logic               Clip,
  input  logic               Clip_clr
);
  logic [LEVEL_W-1:0] g_cur;
  logic adv, acc, ovf;
  logic s1_v_q, s1_v_d, out_valid_q, out_valid_d, clip_q, clip_d;
  logic signed [PROD_W-1:0] prod_q, prod_d, sum;
  logic signed [SCALE_W-1:0] s;
  logic signed [SAMPLE_W-1:0] smp_out_q, smp_out_d, sat;
  gain_sh_e sh_q, sh_d;
  vca_gain_slew #(.SLEW_STEP(SLEW_STEP)) u_slew (
    .Sys_clk   (Sys_clk),
    .Vca_rst_n (Vca_rst_n),
    .Vca_ce    (Vca_ce),
    .Syn_tick  (Syn_tick),
    .Env_lvl   (Env_lvl),
    .g_cur     (g_cur)
  );
  // whole pipeline moves together on adv; stage 1 captures product and shift, stage 2 rounds, shifts and saturates
  always_comb begin
    adv = Vca_ce & (!out_valid_q | out_if.ready);
    acc = adv & smp_if.valid;
    sum = prod_q + PROD_W'(RND);
    s = SCALE_W'(sum >>> 16) <<< sh_q;
    ovf = (s > SCALE_W'(SMP_MAX)) | (s < SCALE_W'(SMP_MIN));
    sat = (s > SCALE_W'(SMP_MAX)) ? SAMPLE_W'(SMP_MAX) : (s < SCALE_W'(SMP_MIN)) ? SAMPLE_W'(SMP_MIN) : s[SAMPLE_W-1:0];
    s1_v_d = adv ? acc : s1_v_q;
    prod_d = acc ? PROD_W'($signed(smp_if.data)) * PROD_W'($signed({1'b0, g_cur})) : prod_q;
    sh_d = acc ? gain_sh_e'(Gain_sh) : sh_q;
    out_valid_d = adv ? s1_v_q : out_valid_q;
    smp_out_d = (adv & s1_v_q) ? sat : smp_out_q;
    clip_d = (adv & s1_v_q & ovf) | (clip_q & !(Vca_ce & Clip_clr));
  end
  // stage registers; reset drops any in-flight samples
  always_ff @(posedge Sys_clk) begin
    if (!Vca_rst_n) begin
      s1_v_q <= 1'b0;
      prod_q <= '0;
      sh_q <= SH_X1;
      out_valid_q <= 1'b0;
      smp_out_q <= '0;
      clip_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      prod_q <= prod_d;
      sh_q <= sh_d;
      out_valid_q <= out_valid_d;
      smp_out_q <= smp_out_d;
      clip_q <= clip_d;
    end
  end
  assign smp_if.ready = adv & Vca_rst_n;
  assign out_if.data = smp_out_q;
  assign out_if.valid = out_valid_q;
  assign Clip = clip_q;
endmodule
